game_input_controller: RTL and testbench
========================================

# game_input_controller

Multi-channel command ingest and pacing block for the Tetris game. It sits between the SPI receiver and one or more game executioners. It captures each received SPI byte exactly once and decodes it into a move/piece command, routes the command to a per-channel show-ahead FIFO, and returns a clear pulse to the SPI block. It also generates the level-dependent gravity tick and an LFSR-randomised piece index, replacing the fixed divider and static piece offset.

## Interface
Parameters:
- NUM_CHANNELS, 2, number of players/executioners (1..4)
- FIFO_DEPTH, 4, commands buffered per channel (power of 2, ≥2)
- GRAVITY_BASE, 4096, gravity period in clk cycles at level 0
- GRAVITY_MIN, 256, minimum gravity period (≥2, ≤GRAVITY_BASE)
- LEVEL_W, 4, width of level input
- LFSR_SEED, 8'hA5, LFSR reset value (nonzero)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  block clock (LSOSC domain)
- reset_n  in  1  synchronous active-low reset
- spi_data  in  8  received byte; synchronous to clk, stable while spi_data_valid=1
- spi_data_valid  in  1  level; high until cleared
- spi_clear  out  1  one-cycle pulse that invalidates the SPI data
- level  in  LEVEL_W  current game level
- cmd_valid  out  [NUM_CHANNELS]  FIFO head valid
- cmd_ready  in  [NUM_CHANNELS]  consumer pop
- cmd_move  out  [NUM_CHANNELS][1:0]  command_t of head
- cmd_move_valid  out  [NUM_CHANNELS]  byte bit 5 of head
- cmd_piece  out  [NUM_CHANNELS][2:0]  piece index 0..6 of head
- drop_count  out  [NUM_CHANNELS][7:0]  saturating count of commands dropped because the FIFO was full
- gravity_tick  out  1  one-cycle pulse

## Operation
- Byte fields: [1:0] move, [4:2] piece field, [5] move_valid, [7:6] channel.
- Ingest FSM states:
  - IDLE: move to PUSH when spi_data_valid=1; latch spi_data and lfsr[2:0].
  - PUSH: decode the latched byte, then go to CLEAR.
    - If channel ≥ NUM_CHANNELS: discard the byte; no drop_count change.
    - Else if the channel FIFO is full: discard and increment drop_count[ch], saturating at 255.
    - Else: write the command into the FIFO.
  - CLEAR: spi_clear=1 for this cycle only, then go to WAIT_RELEASE.
  - WAIT_RELEASE: return to IDLE when spi_data_valid=0. This guarantees one push per byte.
- Piece index:
  - s = piece_field + lfsr[2:0], computed 4 bits wide.
  - If s ≥ 7, subtract 7; if the result is 7, use 0.
  - Result is always 0..6.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Shifts every cycle and never reaches zero.
- FIFO behaviour:
  - Show-ahead; pop occurs on cmd_valid & cmd_ready.
  - Full is the registered occupancy state. A push into a full FIFO is dropped even if a pop happens in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH; the occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide.
- Gravity:
  - period = max(GRAVITY_BASE >> level, GRAVITY_MIN).
  - The counter increments each cycle. When counter ≥ period−1, gravity_tick=1 and the counter resets to 0.
  - A level increase that shortens the period below the current count ticks on the next cycle.
- Reset (any state, including mid-PUSH):
  - state=IDLE; FIFOs empty; all outputs 0; drop_count=0; gravity counter=0; LFSR=LFSR_SEED.
  - A still-high spi_data_valid after reset is captured again.

## Timing
- Cycle N: IDLE samples spi_data_valid=1.
- Cycle N+1: PUSH.
- Cycle N+2: cmd_valid=1 with the new head (if the FIFO was empty); spi_clear=1.
- Cycle N+3: WAIT_RELEASE.
- Minimum byte spacing is 4 cycles.
- Pop at cycle M: the next head, or cmd_valid=0, is visible at M+1.
- gravity_tick is registered: first tick in cycle period after reset release, then every period cycles.

## Structure
- Extend tetris_pkg with:
  - byte field position constants
  - ingest_state_t enum {IDLE, PUSH, CLEAR, WAIT_RELEASE}
  - queued_cmd_t struct {command_t move, logic move_valid, logic [2:0] piece}
- One sub-module, cmd_fifo, parametrised by DEPTH and payload type. Instantiated NUM_CHANNELS times in a generate loop.
- LFSR, piece reduction and gravity counter are inline.

## Test plan
- Reset, then hold byte 8'b00_1_010_01 on valid → at N+2: cmd_valid[0]=1, cmd_move[0]=2'b01, cmd_move_valid[0]=1, cmd_piece[0] = (2+latched lfsr[2:0]) mod 7 per the model; spi_clear high exactly one cycle; no second push while valid stays high for 20 cycles.
- Channel 1, cmd_ready=0, send 6 bytes → 4 entries queued, drop_count[1]=2; then cmd_ready=1 → pops in send order, cmd_valid[1]=0 after the 4th.
- Byte with channel=3, NUM_CHANNELS=2 → no cmd_valid change, drop_count unchanged, spi_clear still pulses at N+2.
- level=0 → gravity_tick at cycles 4096 and 8192; level=5 → period clamps to 256; level changed 0→3 with counter=1000 → tick on the next cycle, then every 512.
- FIFO full, cmd_ready=1 in the PUSH cycle → push dropped, drop_count+1, occupancy becomes DEPTH−1; 260 forced drops → drop_count saturates at 255.
- reset_n low during PUSH → next cycle all cmd_valid=0, spi_clear=0, drop_count=0, LFSR=8'hA5, state IDLE.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared Tetris types: move encoding, SPI command byte layout, ingest FSM states
// and the per-channel queued command payload.
package tetris_pkg;

  typedef enum logic [1:0] {
    CMD_LEFT   = 2'd0,
    CMD_RIGHT  = 2'd1,
    CMD_ROTATE = 2'd2,
    CMD_DROP   = 2'd3
  } command_t;

  localparam int BYTE_MOVE_LSB   = 0;
  localparam int BYTE_PIECE_LSB  = 2;
  localparam int BYTE_MOVE_VALID = 5;
  localparam int BYTE_CHAN_LSB   = 6;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PUSH         = 2'd1,
    CLEAR        = 2'd2,
    WAIT_RELEASE = 2'd3
  } ingest_state_t;

  typedef struct packed {
    command_t   move;
    logic       move_valid;
    logic [2:0] piece;
  } queued_cmd_t;

  // Folds piece field + random offset (0..14) into the seven legal pieces.
  function automatic logic [2:0] reduce_piece(input logic [2:0] field, input logic [2:0] rnd);
    logic [3:0] s;
    s = {1'b0, field} + {1'b0, rnd};
    if (s >= 4'd7) s = s - 4'd7;
    if (s == 4'd7) s = 4'd0;
    return s[2:0];
  endfunction

endpackage

// File: rtl/game_input_controller_cmd_fifo.sv
// Show-ahead command FIFO; head is forced to zero while empty so idle
// outputs read as 0.
module cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  T     push_data,
  output logic full,
  input  logic pop,
  output T     head,
  output logic valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  T            mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign valid   = (count != '0);
  assign full    = (count == DEPTH_CNT);
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head = '0;
    if (valid) head = mem[rd_ptr];
  end

endmodule

// File: rtl/game_input_controller.sv
// SPI command ingest, per-channel command queues, gravity pacing and piece LFSR.
//   state        | meaning
//   IDLE         | wait for spi_data_valid, latch byte and lfsr[2:0]
//   PUSH         | decode latched byte, enqueue or count a drop
//   CLEAR        | pulse spi_clear
//   WAIT_RELEASE | hold until spi_data_valid drops (one push per byte)
module game_input_controller
  import tetris_pkg::*;
#(
  parameter int         NUM_CHANNELS = 2,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         GRAVITY_BASE = 4096,
  parameter int         GRAVITY_MIN  = 256,
  parameter int         LEVEL_W      = 4,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [7:0]                   spi_data,
  input  logic                         spi_data_valid,
  output logic                         spi_clear,
  input  logic [LEVEL_W-1:0]           level,
  output logic [NUM_CHANNELS-1:0]      cmd_valid,
  input  logic [NUM_CHANNELS-1:0]      cmd_ready,
  output logic [NUM_CHANNELS-1:0][1:0] cmd_move,
  output logic [NUM_CHANNELS-1:0]      cmd_move_valid,
  output logic [NUM_CHANNELS-1:0][2:0] cmd_piece,
  output logic [NUM_CHANNELS-1:0][7:0] drop_count,
  output logic                         gravity_tick
);

  localparam int CW = $clog2(GRAVITY_BASE + 1);

  ingest_state_t state, state_nx;
  logic [7:0]    byte_q;
  logic [2:0]    rnd_q;
  logic [7:0]    lfsr;
  logic [1:0]    chan;
  queued_cmd_t   entry;
  queued_cmd_t   head [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] hit, full, push;
  logic [CW-1:0] grav_cnt, shifted, period;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      byte_q <= '0;
      rnd_q  <= '0;
      lfsr   <= LFSR_SEED;
    end else begin
      state <= state_nx;
      lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (state == IDLE && spi_data_valid) begin
        byte_q <= spi_data;
        rnd_q  <= lfsr[2:0];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:         if (spi_data_valid) state_nx = PUSH;
      PUSH:         state_nx = CLEAR;
      CLEAR:        state_nx = WAIT_RELEASE;
      WAIT_RELEASE: if (!spi_data_valid) state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  assign spi_clear = (state == CLEAR);

  assign chan             = byte_q[BYTE_CHAN_LSB +: 2];
  assign entry.move       = command_t'(byte_q[BYTE_MOVE_LSB +: 2]);
  assign entry.move_valid = byte_q[BYTE_MOVE_VALID];
  assign entry.piece      = reduce_piece(byte_q[BYTE_PIECE_LSB +: 3], rnd_q);

  // Channel codes at or above NUM_CHANNELS match no hit bit and vanish silently.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    assign hit[g]  = (state == PUSH) && (chan == 2'(g));
    assign push[g] = hit[g] & ~full[g];

    cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (queued_cmd_t)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push[g]),
      .push_data (entry),
      .full      (full[g]),
      .pop       (cmd_ready[g]),
      .head      (head[g]),
      .valid     (cmd_valid[g])
    );

    assign cmd_move[g]       = head[g].move;
    assign cmd_move_valid[g] = head[g].move_valid;
    assign cmd_piece[g]      = head[g].piece;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (hit[i] && full[i] && drop_count[i] != 8'hFF)
          drop_count[i] <= drop_count[i] + 8'd1;
      end
    end
  end

  always_comb begin
    shifted = CW'(GRAVITY_BASE) >> level;
    period  = (shifted < CW'(GRAVITY_MIN)) ? CW'(GRAVITY_MIN) : shifted;
  end

  // Compare with >= so a shortened period fires immediately rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grav_cnt     <= '0;
      gravity_tick <= 1'b0;
    end else if (grav_cnt >= period - CW'(1)) begin
      grav_cnt     <= '0;
      gravity_tick <= 1'b1;
    end else begin
      grav_cnt     <= grav_cnt + CW'(1);
      gravity_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_game_input_controller.sv
// Randomised bench for game_input_controller against a queue-based reference model.
module tb_game_input_controller;

  localparam int NCH   = 2;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [7:0]          spi_data = '0;
  logic                spi_data_valid = 1'b0;
  logic                spi_clear;
  logic [3:0]          level = '0;
  logic [NCH-1:0]      cmd_valid;
  logic [NCH-1:0]      cmd_ready;
  logic [NCH-1:0][1:0] cmd_move;
  logic [NCH-1:0]      cmd_move_valid;
  logic [NCH-1:0][2:0] cmd_piece;
  logic [NCH-1:0][7:0] drop_count;
  logic                gravity_tick;

  logic                ready_mode = 1'b0;
  logic [NCH-1:0]      ready_force = '0;
  logic [NCH-1:0]      ready_rand = '0;

  assign cmd_ready = ready_mode ? ready_rand : ready_force;

  always #5 clk = ~clk;

  game_input_controller #(
    .NUM_CHANNELS (NCH),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .spi_data       (spi_data),
    .spi_data_valid (spi_data_valid),
    .spi_clear      (spi_clear),
    .level          (level),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_move       (cmd_move),
    .cmd_move_valid (cmd_move_valid),
    .cmd_piece      (cmd_piece),
    .drop_count     (drop_count),
    .gravity_tick   (gravity_tick)
  );

  int checks = 0;
  int errors = 0;

  // Model: each queued entry is move | move_valid<<2 | piece<<3.
  int q [NCH][$];
  int drop_m [NCH];
  int lfsr_m = 8'hA5;
  int gcnt = 0;
  bit tick_m = 1'b0;
  bit pend = 1'b0;
  int pend_byte, pend_entry;
  bit mon_en = 1'b0;
  bit full_b [NCH];

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int v);
    int fb;
    fb = $countones(v & 8'hB8) & 1;
    return ((v << 1) & 8'hFE) | fb;
  endfunction

  function automatic int period_of(input int lv);
    int p;
    p = 4096 >> lv;
    return (p < 256) ? 256 : p;
  endfunction

  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        q[c].delete();
        drop_m[c] = 0;
      end
      lfsr_m = 8'hA5;
      gcnt   = 0;
      tick_m = 1'b0;
      pend   = 1'b0;
    end else begin
      lfsr_m = lfsr_next(lfsr_m);
      if (gcnt >= period_of(int'(level)) - 1) begin
        gcnt = 0;
        tick_m = 1'b1;
      end else begin
        gcnt++;
        tick_m = 1'b0;
      end
      for (int c = 0; c < NCH; c++) full_b[c] = (q[c].size() == DEPTH);
      for (int c = 0; c < NCH; c++)
        if (cmd_ready[c] && q[c].size() > 0) void'(q[c].pop_front());
      if (pend) begin
        int ch;
        ch = pend_byte >> 6;
        if (ch < NCH) begin
          if (full_b[ch]) drop_m[ch] = (drop_m[ch] >= 255) ? 255 : drop_m[ch] + 1;
          else q[ch].push_back(pend_entry);
        end
        pend = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      for (int c = 0; c < NCH; c++) begin
        check("head_valid", int'(cmd_valid[c]), int'(q[c].size() > 0));
        if (q[c].size() > 0) begin
          check("head_move", int'(cmd_move[c]), q[c][0] & 3);
          check("head_mvalid", int'(cmd_move_valid[c]), (q[c][0] >> 2) & 1);
          check("head_piece", int'(cmd_piece[c]), (q[c][0] >> 3) & 7);
        end
        check("drop_count", int'(drop_count[c]), drop_m[c]);
      end
      check("gravity", int'(gravity_tick), int'(tick_m));
    end
  end

  initial forever begin
    @(negedge clk);
    for (int c = 0; c < NCH; c++) ready_rand[c] = ($urandom_range(0, 9) < 3);
  end

  task automatic do_reset();
    spi_data_valid = 1'b0;
    ready_force = '0;
    reset_n = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_clear", int'(spi_clear), 0);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_drops", int'(drop_count), 0);
    check("rst_tick", int'(gravity_tick), 0);
    reset_n = 1'b1;
  endtask

  // Called at a negedge with the DUT in IDLE; returns with the DUT back in IDLE.
  task automatic send_byte(input logic [7:0] b, input int hold, input logic [NCH-1:0] pop_in_push);
    int bi, rnd;
    bi = int'(b);
    spi_data = b;
    spi_data_valid = 1'b1;
    rnd = lfsr_m & 7;
    @(negedge clk);
    check("clr_early", int'(spi_clear), 0);
    pend_entry = (bi & 3) | (((bi >> 5) & 1) << 2) | (((((bi >> 2) & 7) + rnd) % 7) << 3);
    pend_byte = bi;
    pend = 1'b1;
    if (pop_in_push != '0) ready_force = pop_in_push;
    @(negedge clk);
    if (pop_in_push != '0) ready_force = '0;
    check("clr_pulse", int'(spi_clear), 1);
    repeat (hold) begin
      @(negedge clk);
      check("clr_hold", int'(spi_clear), 0);
    end
    spi_data_valid = 1'b0;
    @(negedge clk);
    check("clr_end", int'(spi_clear), 0);
    @(negedge clk);
  endtask

  task automatic wait_tick(input int limit, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!gravity_tick && k < limit);
    check("tick_seen", int'(gravity_tick), 1);
  endtask

  initial begin
    int k;
    @(negedge clk);

    // Single byte held high: exactly one push and one spi_clear pulse.
    do_reset();
    send_byte(8'b00_1_010_01, 20, '0);
    check("hold_valid", int'(cmd_valid[0]), 1);
    check("hold_move", int'(cmd_move[0]), 1);
    ready_force[0] = 1'b1;
    @(negedge clk);
    ready_force[0] = 1'b0;
    check("hold_single", int'(cmd_valid[0]), 0);

    // Channel 1 overflow then ordered drain.
    for (int i = 0; i < 6; i++)
      send_byte({2'b01, 6'($urandom_range(0, 63))}, 0, '0);
    check("ch1_drops", int'(drop_count[1]), 2);
    ready_force[1] = 1'b1;
    repeat (4) @(negedge clk);
    check("ch1_empty", int'(cmd_valid[1]), 0);
    ready_force[1] = 1'b0;

    // Out-of-range channel: ignored but still cleared.
    send_byte({2'b11, 6'($urandom_range(0, 63))}, 0, '0);
    check("ch3_valid", int'(cmd_valid), 0);
    check("ch3_drops", int'(drop_count[1]), 2);

    // Full FIFO with a pop in the PUSH cycle still drops.
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_byte({2'b00, 6'($urandom_range(0, 63))}, 0, '0);
    send_byte({2'b00, 6'($urandom_range(0, 63))}, 0, 2'b01);
    check("pushpop_drop", int'(drop_count[0]), 1);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (cmd_valid[0]) k++;
      ready_force[0] = 1'b1;
      @(negedge clk);
    end
    ready_force[0] = 1'b0;
    check("pushpop_occ", k, DEPTH - 1);

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < DEPTH + 260; i++) send_byte({2'b00, 6'($urandom_range(0, 63))}, 0, '0);
    check("drop_sat", int'(drop_count[0]), 255);

    // Reset during PUSH, then recapture of the still-high byte.
    spi_data = 8'h41;
    spi_data_valid = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", int'(cmd_valid), 0);
    check("midrst_clear", int'(spi_clear), 0);
    check("midrst_drops", int'(drop_count), 0);
    check("midrst_lfsr", int'(dut.lfsr), 8'hA5);
    check("midrst_state", int'(dut.state), 0);
    reset_n = 1'b1;
    send_byte(8'h41, 0, '0);
    check("midrst_recap", int'(cmd_valid[1]), 1);

    // Random traffic, random consumers, random level.
    do_reset();
    ready_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      level = 4'($urandom_range(0, 15));
      send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 2), '0);
    end
    ready_mode = 1'b0;
    ready_force = '1;
    repeat (DEPTH + 2) @(negedge clk);
    check("rand_drained", int'(cmd_valid), 0);
    ready_force = '0;

    // Gravity pacing.
    level = '0;
    do_reset();
    wait_tick(5000, k);
    check("grav_first", k, 4096);
    wait_tick(5000, k);
    check("grav_second", k, 4096);
    level = 4'd5;
    wait_tick(600, k);
    check("grav_clamp", k, 256);
    wait_tick(600, k);
    check("grav_clamp2", k, 256);

    level = '0;
    do_reset();
    repeat (1000) @(negedge clk);
    level = 4'd3;
    @(negedge clk);
    check("grav_jump", int'(gravity_tick), 1);
    wait_tick(1000, k);
    check("grav_512", k, 512);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
